// File: rtl/mode6_sub_seq.sv
// mode6_sub_seq: sequencer for the two-lane softmax "x - max" subtract stage.
// Latches the row maximum on start, streams N packed pairs from the input
// buffer through the external two-lane FP subtract datapath and writes the
// N result pairs to the output buffer, then pulses done for one cycle.
// Optional macro MODE6_SUB_SEQ_PIPE_EN registers the datapath operands,
// adding one stage between the read data and the result capture.
module mode6_sub_seq #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 8,
    parameter int LENWIDTH  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LENWIDTH-1:0]    len,
    input  logic [ADDRWIDTH-1:0]   rd_base,
    input  logic [ADDRWIDTH-1:0]   wr_base,
    input  logic [DATAWIDTH-1:0]   max_in,
    output logic                   rd_en,
    output logic [ADDRWIDTH-1:0]   rd_addr,
    input  logic [2*DATAWIDTH-1:0] rd_data,
    output logic [DATAWIDTH-1:0]   sub_a0,
    output logic [DATAWIDTH-1:0]   sub_a1,
    output logic [DATAWIDTH-1:0]   sub_b,
    input  logic [DATAWIDTH-1:0]   sub_z0,
    input  logic [DATAWIDTH-1:0]   sub_z1,
    output logic                   wr_en,
    output logic [ADDRWIDTH-1:0]   wr_addr,
    output logic [2*DATAWIDTH-1:0] wr_data,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Largest legal length: every address of the buffer exactly once.
    localparam logic [LENWIDTH-1:0] LEN_MAX = LENWIDTH'(1) << ADDRWIDTH;

    state_t                 state_r;
    logic [LENWIDTH-1:0]    rd_left_r;   // reads still to issue after the current one
    logic [ADDRWIDTH-1:0]   wr_ptr_r;    // address of the next write
    logic [DATAWIDTH-1:0]   max_r;       // row maximum latched on accepted start
    logic                   rd_vld_r;    // rd_data carries a requested word this cycle
    logic [LENWIDTH-1:0]    len_eff_s;
    logic                   wr_stage_vld_s;  // datapath result is valid this cycle
    logic                   pipe_busy_s;     // any stage still holds a pair in flight

    // Clamp over-long requests to a full buffer sweep.
    always_comb begin
        len_eff_s = len;
        if (len > LEN_MAX) begin
            len_eff_s = LEN_MAX;
        end else begin
            len_eff_s = len;
        end
    end

`ifdef MODE6_SUB_SEQ_PIPE_EN
    logic                 op_vld_r;
    logic [DATAWIDTH-1:0] sub_a0_r;
    logic [DATAWIDTH-1:0] sub_a1_r;
    logic [DATAWIDTH-1:0] sub_b_r;

    // Operand register stage in front of the datapath; zero when no data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_vld_r <= 1'b0;
            sub_a0_r <= {DATAWIDTH{1'b0}};
            sub_a1_r <= {DATAWIDTH{1'b0}};
            sub_b_r  <= {DATAWIDTH{1'b0}};
        end else begin
            op_vld_r <= rd_vld_r;
            sub_b_r  <= max_r;
            if (rd_vld_r) begin
                sub_a0_r <= rd_data[DATAWIDTH-1:0];
                sub_a1_r <= rd_data[2*DATAWIDTH-1:DATAWIDTH];
            end else begin
                sub_a0_r <= {DATAWIDTH{1'b0}};
                sub_a1_r <= {DATAWIDTH{1'b0}};
            end
        end
    end

    assign sub_a0         = sub_a0_r;
    assign sub_a1         = sub_a1_r;
    assign sub_b          = sub_b_r;
    assign wr_stage_vld_s = op_vld_r;
    assign pipe_busy_s    = rd_vld_r | op_vld_r;
`else
    assign sub_a0         = rd_vld_r ? rd_data[DATAWIDTH-1:0] : {DATAWIDTH{1'b0}};
    assign sub_a1         = rd_vld_r ? rd_data[2*DATAWIDTH-1:DATAWIDTH] : {DATAWIDTH{1'b0}};
    assign sub_b          = max_r;
    assign wr_stage_vld_s = rd_vld_r;
    assign pipe_busy_s    = rd_vld_r;
`endif

    // Control FSM, read issue, result capture and write issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rd_left_r <= {LENWIDTH{1'b0}};
            wr_ptr_r  <= {ADDRWIDTH{1'b0}};
            max_r     <= {DATAWIDTH{1'b0}};
            rd_vld_r  <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= {ADDRWIDTH{1'b0}};
            wr_en     <= 1'b0;
            wr_addr   <= {ADDRWIDTH{1'b0}};
            wr_data   <= {(2*DATAWIDTH){1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Read data arrives one cycle after the strobe.
            rd_vld_r <= rd_en;

            // Write stage: capture the datapath result for every valid pair.
            if (wr_stage_vld_s) begin
                wr_en    <= 1'b1;
                wr_addr  <= wr_ptr_r;
                wr_ptr_r <= wr_ptr_r + ADDRWIDTH'(1);
                wr_data  <= {sub_z1, sub_z0};
            end else begin
                wr_en    <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        max_r    <= max_in;
                        wr_ptr_r <= wr_base;
                        if (len_eff_s == {LENWIDTH{1'b0}}) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r   <= ST_RUN;
                            rd_en     <= 1'b1;
                            rd_addr   <= rd_base;
                            rd_left_r <= len_eff_s - LENWIDTH'(1);
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_left_r == {LENWIDTH{1'b0}}) begin
                        rd_en   <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_addr   <= rd_addr + ADDRWIDTH'(1);
                        rd_left_r <= rd_left_r - LENWIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // Nothing left in flight: the final write is on the bus now.
                    if (!pipe_busy_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_en   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
